// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready handshake on both sides.
//   Single-cycle ops (ADD SUB SLL SRL XOR OR AND LT SRA SLT, illegal) finish
//   one cycle after accept. MUL (shift-add, LSB first) and DIV/REM (unsigned
//   restoring division, MSB first) take WORD_SIZE+1 cycles. A result is held
//   until the consumer takes it.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operation handshake (in_ready only in IDLE)
//   A, B, operation   operands and 4-bit opcode, captured on accept
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   result, zero      registered result and its zero flag
//   illegal           accepted opcode was 13..15
//   busy              FSM is not IDLE
module alu_mc #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned SHAMT_W   = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] A,
  input  logic [WORD_SIZE-1:0] B,
  input  logic [3:0]           operation,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] result,
  output logic                 zero,
  output logic                 illegal,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(WORD_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_LT  = 4'd9;
  localparam logic [3:0] OP_REM = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_SLT = 4'd12;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [WORD_SIZE-1:0] a_q, a_d;      // MUL: shifted multiplicand; DIV/REM: dividend -> quotient
  logic [WORD_SIZE-1:0] b_q, b_d;      // MUL: multiplier shifted right; DIV/REM: divisor
  logic [WORD_SIZE-1:0] acc_q, acc_d;  // MUL: product; DIV/REM: partial remainder
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;

  // Single-cycle datapath
  logic [SHAMT_W-1:0]   shamt;
  logic [WORD_SIZE-1:0] sc_res;
  logic                 sc_ill;

  always_comb begin
    shamt  = B[SHAMT_W-1:0];
    sc_res = '0;
    sc_ill = 1'b0;
    case (operation)
      OP_ADD: sc_res = A + B;
      OP_SUB: sc_res = A - B;
      OP_SLL: sc_res = A << shamt;
      OP_SRL: sc_res = A >> shamt;
      OP_XOR: sc_res = A ^ B;
      OP_OR:  sc_res = A | B;
      OP_AND: sc_res = A & B;
      OP_LT:  sc_res = {{(WORD_SIZE-1){1'b0}}, (A < B)};
      OP_SRA: sc_res = $signed(A) >>> shamt;
      OP_SLT: sc_res = {{(WORD_SIZE-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_MUL, OP_DIV, OP_REM: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply / restoring divide
  logic [WORD_SIZE-1:0] mul_acc_nx;
  logic [WORD_SIZE:0]   rem_sh;
  logic [WORD_SIZE:0]   rem_diff;
  logic                 q_bit;
  logic [WORD_SIZE-1:0] rem_nx;
  logic [WORD_SIZE-1:0] quo_nx;
  logic [WORD_SIZE-1:0] iter_res;

  always_comb begin
    mul_acc_nx = b_q[0] ? (acc_q + a_q) : acc_q;
    rem_sh     = {acc_q, a_q[WORD_SIZE-1]};
    rem_diff   = rem_sh - {1'b0, b_q};
    // No borrow means the shifted remainder covers the divisor; a zero
    // divisor never borrows, giving an all-ones quotient and remainder = A.
    q_bit      = ~rem_diff[WORD_SIZE];
    rem_nx     = q_bit ? rem_diff[WORD_SIZE-1:0] : rem_sh[WORD_SIZE-1:0];
    quo_nx     = {a_q[WORD_SIZE-2:0], q_bit};
    case (op_q)
      OP_MUL:  iter_res = mul_acc_nx;
      OP_DIV:  iter_res = quo_nx;
      default: iter_res = rem_nx;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = operation;
          if (operation == OP_MUL || operation == OP_DIV || operation == OP_REM) begin
            state_d = S_ITER;
            cnt_d   = '0;
            a_d     = A;
            b_d     = B;
            acc_d   = '0;
          end else begin
            state_d   = S_DONE;
            result_d  = sc_res;
            zero_d    = (sc_res == '0);
            illegal_d = sc_ill;
          end
        end
      end
      S_ITER: begin
        if (op_q == OP_MUL) begin
          acc_d = mul_acc_nx;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = rem_nx;
          a_d   = quo_nx;
        end
        // The last iteration writes the result directly, so DONE is
        // reached WORD_SIZE+1 cycles after accept.
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          result_d  = iter_res;
          zero_d    = (iter_res == '0);
          illegal_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc at WORD_SIZE=8: directed cases plus randomized
// operations against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   operation;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .operation(operation), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic logic [W-1:0] ref_result(input int op, input int a, input int b);
    int sh;
    int r;
    sh = b % 8;
    case (op)
      0:  r = (a + b) % 256;
      1:  r = (a - b + 256) % 256;
      2:  r = (a * b) % 256;
      3:  r = (b == 0) ? 255 : a / b;
      4:  r = (a << sh) & 255;
      5:  r = a >> sh;
      6:  r = a ^ b;
      7:  r = a | b;
      8:  r = a & b;
      9:  r = (a < b) ? 1 : 0;
      10: r = (b == 0) ? a : a % b;
      11: r = (to_signed(a) >>> sh) & 255;
      12: r = (to_signed(a) < to_signed(b)) ? 1 : 0;
      default: r = 0;
    endcase
    return W'(r);
  endfunction

  function automatic int ref_latency(input int op);
    return (op == 2 || op == 3 || op == 10) ? W + 1 : 1;
  endfunction

  // Starts at #1 after a rising edge with the DUT idle.
  task automatic run_op(input int op, input int a, input int b, input int hold);
    int n;
    logic [W-1:0] exp;
    exp = ref_result(op, a, b);
    check("in_ready_before", 32'(in_ready), 32'd1);
    A = W'(a); B = W'(b); operation = 4'(op);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    A = W'($urandom); B = W'($urandom); operation = 4'($urandom);
    n = 1;
    while (!out_valid && n < 20) begin
      check("in_ready_iter", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(ref_latency(op)));
    check("out_valid", 32'(out_valid), 32'd1);
    check("result", 32'(result), 32'(exp));
    check("zero", 32'(zero), 32'(exp == '0));
    check("illegal", 32'(illegal), 32'(op > 12));
    check("busy", 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      A = W'($urandom); B = W'($urandom); operation = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(exp));
      check("hold_flags", {30'd0, zero, illegal}, {30'd0, (exp == '0), (op > 12)});
    end
    // Still in DONE: a request with out_ready high must not be accepted.
    in_valid = 1'b1; operation = 4'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("no_accept_in_done", {29'd0, in_ready, out_valid, busy}, 32'b100);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; operation = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, zero, illegal, busy}, 32'b100);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 8'hF0, 8'h20, 0);
    run_op(2, 8'h0F, 8'h11, 0);
    run_op(3, 200, 0, 0);
    run_op(10, 200, 7, 0);
    run_op(3, 200, 7, 0);
    run_op(11, 8'h80, 8'h0B, 0);
    run_op(12, 8'hFF, 8'h01, 0);
    run_op(9, 8'hFF, 8'h01, 0);
    run_op(1, 8'h33, 8'h33, 0);
    run_op(0, 8'h12, 8'h34, 5);
    run_op(14, 8'h55, 8'hAA, 0);
    run_op(2, 8'hAB, 8'hCD, 3);

    // Reset in the middle of a multiply aborts it.
    A = 8'h0F; B = 8'h11; operation = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_iter_busy", 32'(busy), 32'd1);
    rst = 1'b1; in_valid = 1'b1; operation = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", {29'd0, zero, illegal, busy}, 32'b100);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    run_op(0, 8'h01, 8'h02, 0);

    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, operand and result width; legal range 4..64.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WORD_SIZE), number of B bits used as shift amount.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 A  input  WORD_SIZE  first operand.
REQ-008 B  input  WORD_SIZE  second operand.
REQ-009 operation  input  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SLL, 5 SRL, 6 XOR, 7 OR, 8 AND, 9 LT, 10 REM, 11 SRA, 12 SLT; 13-15 illegal.
REQ-010 out_valid  output  1  result, zero, illegal are valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WORD_SIZE  operation result, registered.
REQ-013 zero  output  1  result == 0, registered with result.
REQ-014 illegal  output  1  accepted opcode was 13-15.
REQ-015 busy  output  1  state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ITER, DONE; in_ready = (state == IDLE).
REQ-017 Accept = in_valid & in_ready; A, B, operation SHALL be captured on accept; inputs ignored otherwise.
REQ-018 Single-cycle ops (0,1,4-9,11,12, illegal): IDLE->DONE on accept; out_valid asserted the cycle after accept (latency 1).
REQ-019 MUL, DIV, REM: IDLE->ITER on accept; iteration counter runs WORD_SIZE cycles; ITER->DONE after last iteration; out_valid asserted exactly WORD_SIZE+1 cycles after accept.
REQ-020 DONE->IDLE when out_ready is high; while out_ready low, result, zero, illegal, out_valid SHALL hold unchanged.
REQ-021 No new accept in DONE even if out_ready is high same cycle; next accept earliest one cycle later in IDLE.
REQ-022 ADD/SUB/MUL SHALL return low WORD_SIZE bits, wrap-around modulo 2^WORD_SIZE, no carry/overflow flag.
REQ-023 MUL SHALL be iterative shift-add, one bit of B per cycle, LSB first; unsigned.
REQ-024 DIV/REM SHALL be unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-025 B == 0: DIV result all-ones, REM result = A; same latency as nonzero divisor.
REQ-026 Shifts SHALL use B[SHAMT_W-1:0] only; SLL/SRL zero-fill; SRA replicates A[WORD_SIZE-1].
REQ-027 LT unsigned, SLT two's-complement signed; result = {WORD_SIZE-1 zeros, compare bit}.
REQ-028 Illegal opcode: result 0, zero 1, illegal 1; all legal ops drive illegal 0.
REQ-029 zero SHALL be computed from final result, not intermediate iteration state.
REQ-030 No combinational path from any input to any output except none; in_ready, out_valid decode state only.

Reset
REQ-031 rst high at a clock edge SHALL force state IDLE, counter 0, result 0, zero 1, illegal 0, out_valid 0, busy 0, in_ready 1 from the following cycle.
REQ-032 rst mid-ITER or in DONE SHALL abort the operation; no out_valid for it is ever produced.
REQ-033 rst SHALL take priority over accept and out_ready in the same cycle.

Verification (WORD_SIZE=8)
REQ-034 ADD A=0xF0 B=0x20, out_ready=1 -> out_valid cycle 1 after accept, result 0x10, zero 0.
REQ-035 MUL A=0x0F B=0x11 -> out_valid exactly 9 cycles after accept, result 0xFF; in_ready 0 throughout.
REQ-036 DIV A=200 B=0 -> result 0xFF at cycle 9; REM A=200 B=7 -> result 4; DIV A=200 B=7 -> 28.
REQ-037 SRA A=0x80 B=0x0B (shamt 3) -> 0xF0; SLT A=0xFF B=0x01 -> 1; LT same -> 0; SUB A=B=0x33 -> 0, zero 1.
REQ-038 out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_valid ignored; opcode 14 -> illegal 1, result 0.
REQ-039 rst asserted at ITER cycle 4 of a MUL -> next cycle IDLE, out_valid 0, result 0; following ADD completes normally.
